// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU controller: opcodes, FSM states, strobe bundle.
package cpu_pkg;

  localparam int AW = 13;

  localparam logic [2:0] HLT  = 3'd0;
  localparam logic [2:0] SKZ  = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] ANDD = 3'd3;
  localparam logic [2:0] XORR = 3'd4;
  localparam logic [2:0] LDA  = 3'd5;
  localparam logic [2:0] STO  = 3'd6;
  localparam logic [2:0] JMP  = 3'd7;

  typedef enum logic [2:0] {IDLE, F1, F2, DEC, EX1, EX2, EX3, HALT} state_t;

  typedef struct packed {
    logic alu_ena;
    logic load_acc;
    logic inc_pc;
    logic load_pc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } strobe_t;

  // Ops that read a memory operand into the ALU.
  function automatic logic is_operand_op(input logic [2:0] op);
    return (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decode from {state, opcode, latched zero}; zero latency, no backpressure.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  state_t     state_i,
  input  logic [2:0] opcode_i,
  input  logic       zero_q_i,
  output strobe_t    strb_o
);

  logic operand;
  assign operand = is_operand_op(opcode_i);

  always_comb begin
    strb_o = '0;
    case (state_i)
      F1, F2: begin
        strb_o.rd     = 1'b1;
        strb_o.inc_pc = 1'b1;
      end
      EX1: begin
        if (operand)              strb_o.rd          = 1'b1;
        else if (opcode_i == STO) strb_o.datactl_ena = 1'b1;
        else if (opcode_i == JMP) strb_o.load_pc     = 1'b1;
        else if (opcode_i == SKZ) strb_o.inc_pc      = zero_q_i;
      end
      EX2: begin
        if (operand) begin
          strb_o.rd      = 1'b1;
          strb_o.alu_ena = 1'b1;
        end else if (opcode_i == STO) begin
          strb_o.datactl_ena = 1'b1;
          strb_o.wr          = 1'b1;
        end else if (opcode_i == SKZ) begin
          // Second increment of the skip: together they step over one two-byte instruction.
          strb_o.inc_pc = zero_q_i;
        end
      end
      EX3: begin
        if (operand)              strb_o.load_acc    = 1'b1;
        else if (opcode_i == STO) strb_o.datactl_ena = 1'b1;
      end
      HALT:    strb_o.halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Six-cycle fetch/execute sequencer (HLT: three, then halted); waits in IDLE while ena is low.
// CPU_CTRL_STEP_EN adds a 'step' input so each instruction start also needs a step pulse.
module cpu_ctrl
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [7:0]    data,
  input  logic          zero,
`ifdef CPU_CTRL_STEP_EN
  input  logic          step,
`endif
  output logic [2:0]    opcode,
  output logic [AW-1:0] ir_addr,
  output logic          alu_ena,
  output logic          load_acc,
  output logic          inc_pc,
  output logic          load_pc,
  output logic          rd,
  output logic          wr,
  output logic          datactl_ena,
  output logic          halt
);

  state_t     state_q;
  logic [7:0] ir_hi_q;
  logic [7:0] ir_lo_q;
  logic       zero_q;
  logic       go;
  strobe_t    strb;

`ifdef CPU_CTRL_STEP_EN
  assign go = ena & step;
`else
  assign go = ena;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_hi_q <= 8'h00;
      ir_lo_q <= 8'h00;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (go) state_q <= F1;
        F1: begin
          ir_hi_q <= data;
          state_q <= F2;
        end
        F2: begin
          ir_lo_q <= data;
          state_q <= DEC;
        end
        DEC: begin
          zero_q  <= zero;
          state_q <= (ir_hi_q[7:5] == HLT) ? HALT : EX1;
        end
        EX1:     state_q <= EX2;
        EX2:     state_q <= EX3;
        EX3:     state_q <= go ? F1 : IDLE;
        HALT:    state_q <= HALT;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign opcode  = ir_hi_q[7:5];
  assign ir_addr = {ir_hi_q[4:0], ir_lo_q};

  cpu_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .zero_q_i (zero_q),
    .strb_o   (strb)
  );

  assign alu_ena     = strb.alu_ena;
  assign load_acc    = strb.load_acc;
  assign inc_pc      = strb.inc_pc;
  assign load_pc     = strb.load_pc;
  assign rd          = strb.rd;
  assign wr          = strb.wr;
  assign datactl_ena = strb.datactl_ena;
  assign halt        = strb.halt;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: per-cycle strobe vectors, IR contents, halt and async reset.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [7:0]  data;
  logic        zero;
`ifdef CPU_CTRL_STEP_EN
  logic        step;
`endif
  logic [2:0]  opcode;
  logic [12:0] ir_addr;
  logic        alu_ena, load_acc, inc_pc, load_pc, rd, wr, datactl_ena, halt;

  int n_cmp = 0;
  int n_err = 0;

  // Strobe vector bits: alu_ena 80, load_acc 40, inc_pc 20, load_pc 10, rd 08, wr 04, datactl_ena 02, halt 01.
  logic [7:0] strb;
  assign strb = {alu_ena, load_acc, inc_pc, load_pc, rd, wr, datactl_ena, halt};

  always #5 clk = ~clk;

  cpu_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .data        (data),
    .zero        (zero),
`ifdef CPU_CTRL_STEP_EN
    .step        (step),
`endif
    .opcode      (opcode),
    .ir_addr     (ir_addr),
    .alu_ena     (alu_ena),
    .load_acc    (load_acc),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at the negedge of F1; leaves at the negedge of the cycle after EX3.
  task automatic exec(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                      input logic zd, input logic ze, input logic drop,
                      input logic [47:0] seq, input logic [2:0] op,
                      input logic [12:0] addr, input int incs);
    int n_inc;
    n_inc = 0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("%s.strb%0d", tag, i), {24'h0, strb}, {24'h0, seq[47-8*i -: 8]});
      if (inc_pc) n_inc++;
      if (i == 2 || i == 5) begin
        chk($sformatf("%s.op%0d", tag, i), {29'h0, opcode}, {29'h0, op});
        chk($sformatf("%s.addr%0d", tag, i), {19'h0, ir_addr}, {19'h0, addr});
      end
      case (i)
        0: data = b0;
        1: data = b1;
        2: zero = zd;
        3: begin
          zero = ze;
          if (drop) ena = 1'b0;
        end
        default: ;
      endcase
      tick();
    end
    chk($sformatf("%s.incs", tag), n_inc, incs);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    data  = 8'h00;
    zero  = 1'b0;
`ifdef CPU_CTRL_STEP_EN
    step  = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk("rst.strb", {24'h0, strb}, 32'h0);
    chk("rst.addr", {19'h0, ir_addr}, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle.strb%0d", i), {24'h0, strb}, 32'h0);
    end
    chk("idle.op", {29'h0, opcode}, 32'h0);
    chk("idle.addr", {19'h0, ir_addr}, 32'h0);

    ena = 1'b1;
    tick();
    exec("add",  8'h45, 8'h12, 1'b0, 1'b0, 1'b0, 48'h28_28_00_08_88_40, 3'd2, 13'h0512, 2);
    exec("skz1", 8'h20, 8'h00, 1'b1, 1'b1, 1'b0, 48'h28_28_00_20_20_00, 3'd1, 13'h0000, 4);
    exec("skz0", 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 48'h28_28_00_00_00_00, 3'd1, 13'h0000, 2);
    exec("sto",  8'hC0, 8'h33, 1'b0, 1'b0, 1'b0, 48'h28_28_00_02_06_02, 3'd6, 13'h0033, 2);
    exec("jmp",  8'hE1, 8'h00, 1'b0, 1'b0, 1'b1, 48'h28_28_00_10_00_00, 3'd7, 13'h0100, 2);

    // ena dropped during the JMP: the block should now sit in IDLE.
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("drop.strb%0d", i), {24'h0, strb}, 32'h0);
      tick();
    end

    ena = 1'b1;
    tick();
    chk("hlt.f1", {24'h0, strb}, 32'h28);
    data = 8'h00;
    tick();
    chk("hlt.f2", {24'h0, strb}, 32'h28);
    tick();
    chk("hlt.dec", {24'h0, strb}, 32'h00);
    chk("hlt.op", {29'h0, opcode}, 32'h0);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("halt%0d", i), {24'h0, strb}, 32'h01);
      ena = ~ena;
      tick();
    end

    // Asynchronous reset in EX2 of an ADD.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    ena = 1'b1;
    tick();
    data = 8'h45;
    tick();
    data = 8'h12;
    tick();
    tick();
    tick();
    chk("mid.ex2", {24'h0, strb}, 32'h88);
    chk("mid.addr_pre", {19'h0, ir_addr}, 32'h0512);
    ena = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid.strb", {24'h0, strb}, 32'h0);
    chk("mid.op", {29'h0, opcode}, 32'h0);
    chk("mid.addr", {19'h0, ir_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid.idle", {24'h0, strb}, 32'h0);

`ifdef CPU_CTRL_STEP_EN
    step = 1'b0;
    ena  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("step.wait%0d", i), {24'h0, strb}, 32'h0);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    exec("step", 8'h45, 8'h12, 1'b0, 1'b0, 1'b0, 48'h28_28_00_08_88_40, 3'd2, 13'h0512, 2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("step.idle%0d", i), {24'h0, strb}, 32'h0);
      tick();
    end
    step = 1'b1;
    tick();
    chk("step.f1", {24'h0, strb}, 32'h28);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
